// File: rtl/drm_fifo_ctrl.sv
// drm_fifo_ctrl: FIFO controller in front of an external simple-dual-port RAM.
// The RAM has a one-cycle registered read. A two-entry output buffer
// (head plus skid) hides that latency, so the FIFO streams one word per cycle.
// Optional feature: define DRM_FIFO_AFULL_EN to add the registered 'afull' output.
module drm_fifo_ctrl #(
  parameter int DATA_WIDTH   = 20,
  parameter int ADDR_WIDTH   = 8,
  parameter int AFULL_THRESH = 240
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH+1:0] level,
`ifdef DRM_FIFO_AFULL_EN
  output logic                  afull,
`endif
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int CW    = ADDR_WIDTH + 1;
  localparam int LW    = ADDR_WIDTH + 2;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_ram_cnt;
  logic [1:0]            r_ob_cnt;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [LW-1:0]         r_level;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic [1:0]            w_occ;
  logic [LW-1:0]         w_level_nxt;

  // Reset also gates the write strobe, so the RAM is never written while in reset.
  assign in_ready    = (r_ram_cnt != CW'(DEPTH));
  assign w_push      = rst_n && in_valid && in_ready;
  assign out_valid   = (r_ob_cnt != 2'd0);
  assign out_data    = r_head;
  assign w_pop       = out_valid && out_ready;
  assign w_occ       = r_ob_cnt + {1'b0, r_inflight};
  // A read may only be issued if its word is guaranteed a slot in the output buffer.
  assign w_issue     = (r_ram_cnt != '0) &&
                       ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));

  assign ram_wr_en   = w_push;
  assign ram_wr_addr = r_wr_ptr;
  assign ram_wr_data = in_data;
  assign ram_rd_addr = r_rd_ptr;
  assign level       = r_level;

  // Next occupancy count: a push adds one, a pop removes one.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // RAM pointers advance on a push or a read issue and wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_issue) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
    end
  end

  // Track words written to RAM that have not yet been read-issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_cnt <= '0;
    end else begin
      case ({w_push, w_issue})
        2'b10:   r_ram_cnt <= r_ram_cnt + CW'(1);
        2'b01:   r_ram_cnt <= r_ram_cnt - CW'(1);
        default: r_ram_cnt <= r_ram_cnt;
      endcase
    end
  end

  // Capture returning RAM data into head/skid and shift on pops, keeping order.
  // Clearing inflight on reset stops stale RAM read data from ever being captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_ob_cnt   <= 2'd0;
      r_head     <= '0;
      r_skid     <= '0;
    end else begin
      r_inflight <= w_issue;
      case ({r_inflight, w_pop})
        2'b11: begin
          if (r_ob_cnt == 2'd2) begin
            r_head <= r_skid;
            r_skid <= ram_rd_data;
          end else begin
            r_head <= ram_rd_data;
          end
        end
        2'b01: begin
          if (r_ob_cnt == 2'd2) r_head <= r_skid;
          r_ob_cnt <= r_ob_cnt - 2'd1;
        end
        2'b10: begin
          if (r_ob_cnt == 2'd0) r_head <= ram_rd_data;
          else                  r_skid <= ram_rd_data;
          r_ob_cnt <= r_ob_cnt + 2'd1;
        end
        default: r_ob_cnt <= r_ob_cnt;
      endcase
    end
  end

  // Total words held across RAM, the in-flight read and the output buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_level <= '0;
    else        r_level <= w_level_nxt;
  end

`ifdef DRM_FIFO_AFULL_EN
  logic r_afull;
  assign afull = r_afull;

  // Almost-full is registered from the next level so it always agrees with 'level'.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_afull <= 1'b0;
    else        r_afull <= (w_level_nxt >= LW'(AFULL_THRESH));
  end
`endif

endmodule

// File: tb/tb_drm_fifo_ctrl.sv
// tb_drm_fifo_ctrl: directed bench for drm_fifo_ctrl with a behavioural SDP RAM
// and a queue scoreboard. Define DRM_FIFO_AFULL_EN to also exercise 'afull'.
module tb_drm_fifo_ctrl;

  localparam int DW = 20;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW+1:0] level;
`ifdef DRM_FIFO_AFULL_EN
  logic          afull;
`endif
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_wr_addr;
  logic          ram_wr_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int            passCount  = 0;
  int            checkCount = 0;
  logic [DW-1:0] expQ [$];
  logic          prevStall  = 1'b0;
  logic [DW-1:0] prevData   = '0;

  drm_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(240)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
`ifdef DRM_FIFO_AFULL_EN
    .afull      (afull),
`endif
    .ram_wr_data(ram_wr_data),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_en  (ram_wr_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural SDP RAM with a registered read port and no output register.
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Drive one cycle of inputs, then at the falling edge update the scoreboard.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r);
    logic [DW-1:0] exp;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    checkOutput("levelTrack", 32'(level), 32'(expQ.size()));
    if (prevStall) begin
      checkOutput("stallValid", 32'(out_valid), 32'd1);
      checkOutput("stallData", 32'(out_data), 32'(prevData));
    end
    if (out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedPop", 32'(out_data), 32'hFFFFFFFF);
      end else begin
        exp = expQ.pop_front();
        checkOutput("dataOut", 32'(out_data), 32'(exp));
      end
    end
    if (in_valid && in_ready) expQ.push_back(in_data);
    prevStall = out_valid && !out_ready;
    prevData  = out_data;
  endtask

  // Release out_ready until everything queued has left, with a cycle bound.
  task automatic drainAll(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (expQ.size() == 0 && level == 0) break;
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("drainEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("drainLevel", 32'(level), 32'd0);
  endtask

  initial begin
    int            bubbles;
    logic          seen;
    logic [DW-1:0] firstOut;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 20'h00005;
    out_ready = 1'b0;
    #12;
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstInReady", 32'(in_ready), 32'd1);
    checkOutput("rstLevel", 32'(level), 32'd0);
    checkOutput("rstWrEn", 32'(ram_wr_en), 32'd0);
    checkOutput("rstRdAddr", 32'(ram_rd_addr), 32'd0);
    checkOutput("rstOutData", 32'(out_data), 32'd0);
`ifdef DRM_FIFO_AFULL_EN
    checkOutput("rstAfull", 32'(afull), 32'd0);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Single word latency: push in cycle 0, visible in cycle 3, gone by cycle 4.
    $display("[TB] single word latency");
    applyStimulus(1'b1, 20'h00001, 1'b1);
    checkOutput("c0WrEn", 32'(ram_wr_en), 32'd1);
    checkOutput("c0WrAddr", 32'(ram_wr_addr), 32'd0);
    checkOutput("c0WrData", 32'(ram_wr_data), 32'h1);
    checkOutput("c0OutValid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("c1Level", 32'(level), 32'd1);
    checkOutput("c1RdAddr", 32'(ram_rd_addr), 32'd0);
    checkOutput("c1OutValid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("c2RdAddr", 32'(ram_rd_addr), 32'd1);
    checkOutput("c2OutValid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("c3OutValid", 32'(out_valid), 32'd1);
    checkOutput("c3OutData", 32'(out_data), 32'h1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("c4Level", 32'(level), 32'd0);
    checkOutput("c4OutValid", 32'(out_valid), 32'd0);

    // Fill to 258 words with the consumer stalled, then offer one more.
    $display("[TB] fill to full");
    for (int c = 0; c < 258; c++) begin
      applyStimulus(1'b1, 20'(32'h100 + c), 1'b0);
      if (c < 257) checkOutput("fillReady", 32'(in_ready), 32'd1);
`ifdef DRM_FIFO_AFULL_EN
      if (c == 239) checkOutput("afullAt239", 32'(afull), 32'd0);
      if (c == 240) checkOutput("afullAt240", 32'(afull), 32'd1);
`endif
    end
    applyStimulus(1'b1, 20'h00999, 1'b0);
    checkOutput("fullLevel", 32'(level), 32'd258);
    checkOutput("fullInReady", 32'(in_ready), 32'd0);
    checkOutput("fullWrEn", 32'(ram_wr_en), 32'd0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("fullLevelHold", 32'(level), 32'd258);
    drainAll(400);

    // Continuous streaming with wrapping pointers: no bubbles after cycle 3.
    $display("[TB] streaming 1000 words");
    bubbles = 0;
    for (int c = 0; c < 1003; c++) begin
      applyStimulus(c < 1000, 20'(c), 1'b1);
      if (c >= 3 && !out_valid) bubbles++;
    end
    checkOutput("streamBubbles", 32'(bubbles), 32'd0);
    drainAll(20);

    // Random producer and consumer activity.
    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 20'($urandom), 1'($urandom_range(0, 1)));
    end
    drainAll(600);

    // Reset in the middle of operation with 100 words held.
    $display("[TB] reset mid-operation");
    for (int c = 0; c < 100; c++) applyStimulus(1'b1, 20'(32'h7000 + c), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("preRstLevel", 32'(level), 32'd100);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
    checkOutput("midRstLevel", 32'(level), 32'd0);
    checkOutput("midRstInReady", 32'(in_ready), 32'd1);
    expQ.delete();
    prevStall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen     = 1'b0;
    firstOut = '0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(c == 0, 20'hABCDE, 1'b1);
      if (out_valid) begin
        seen     = 1'b1;
        firstOut = out_data;
        break;
      end
    end
    checkOutput("postRstSeen", 32'(seen), 32'd1);
    checkOutput("postRstFirst", 32'(firstOut), 32'hABCDE);
    drainAll(20);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/drm_fifo_ctrl.md
DRM_FIFO_CTRL -- requirements
Module: drm_fifo_ctrl

Interface
REQ-001 Parameters: DATA_WIDTH, default 20, word width; ADDR_WIDTH, default 8, RAM address width (depth 2^ADDR_WIDTH = 256); AFULL_THRESH, default 240, almost-full level.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_data  input  DATA_WIDTH  write word.
REQ-005 in_valid  input  1  write request.
REQ-006 in_ready  output  1  space available; a push occurs when in_valid && in_ready.
REQ-007 out_data  output  DATA_WIDTH  head word.
REQ-008 out_valid  output  1  head word valid.
REQ-009 out_ready  input  1  consumer accept; a pop occurs when out_valid && out_ready.
REQ-010 level  output  ADDR_WIDTH+2  total words held (RAM + in-flight + output buffer), 0..258.
REQ-011 ram_wr_data  output  DATA_WIDTH  to SDP RAM write data.
REQ-012 ram_wr_addr  output  ADDR_WIDTH  to SDP RAM write address.
REQ-013 ram_wr_en  output  1  to SDP RAM write enable.
REQ-014 ram_rd_addr  output  ADDR_WIDTH  to SDP RAM read address.
REQ-015 ram_rd_data  input  DATA_WIDTH  from SDP RAM; valid the cycle after ram_rd_addr is sampled (no output register).

Function
REQ-016 A push drives ram_wr_en=1, ram_wr_addr=wr_ptr, ram_wr_data=in_data combinationally in the same cycle; wr_ptr increments, wrapping 255->0.
REQ-017 ram_cnt (0..256) counts words written but not yet read-issued; in_ready = (ram_cnt != 256), decoded from registered state.
REQ-018 The output buffer holds at most 2 words (head register plus skid entry); inflight (0/1) marks a RAM read issued the previous cycle.
REQ-019 A read is issued (ram_rd_addr = rd_ptr, rd_ptr increments with wrap, ram_cnt decrements) when ram_cnt > 0 and (ob_cnt + inflight < 2, or ob_cnt + inflight == 2 with a pop in the same cycle).
REQ-020 When inflight=1, ram_rd_data is captured into the output buffer at the end of that cycle; words leave the buffer in order.
REQ-021 Latency: a word pushed in cycle N into an empty FIFO has out_valid=1 from cycle N+3.
REQ-022 With in_valid and out_ready held high, throughput is 1 word/cycle with no bubbles after the initial latency.
REQ-023 A push and a read issue in the same cycle update ram_cnt by net 0; a push with ram_cnt==0 is never read in the same cycle.
REQ-024 level updates every cycle: +1 on push, -1 on pop, unchanged when both occur.
REQ-025 out_data and out_valid remain stable while out_valid && !out_ready.

Reset
REQ-026 While rst_n=0: wr_ptr, rd_ptr, ram_cnt, ob_cnt, inflight, level = 0; out_valid=0; in_ready=1; ram_wr_en=0; ram_rd_addr=0; out_data=0.
REQ-027 Reset asserted mid-operation discards all held words immediately; RAM contents are not cleared, and stale RAM data is never presented.

Configuration
REQ-028 Macro DRM_FIFO_AFULL_EN defined: output port afull (1 bit) is present, registered, reset 0, and equals 1 exactly when level >= AFULL_THRESH.
REQ-029 Macro DRM_FIFO_AFULL_EN undefined: port afull and its logic are absent; all other behaviour is unchanged.

Verification
REQ-030 Push 0x00001 in cycle 0, out_ready=1 -> out_valid=1 with out_data=0x00001 in cycle 3; level returns to 0 in cycle 4.
REQ-031 Push 258 words, out_ready=0 -> in_ready=0 after the 256th RAM word is held, level=258, ram_cnt=256; the 259th in_valid is not accepted.
REQ-032 Stream 1000 incrementing words with in_valid=out_ready=1 -> output identical in order, 1 word/cycle after cycle 3, pointers wrap 255->0 without loss.
REQ-033 Random out_ready toggling with 50% in_valid -> no loss, duplication, or reordering; out_data is stable during stalls.
REQ-034 Assert rst_n=0 with level=100 -> out_valid=0, level=0, and in_ready=1 during reset; after release, push 0xABCDE -> 0xABCDE is the first output.
REQ-035 With DRM_FIFO_AFULL_EN defined and AFULL_THRESH=240 -> afull=0 at level 239 and afull=1 at level 240.
